serial_capture_arb: RTL and testbench

SERIAL_CAPTURE_ARB -- requirements
Module: serial_capture_arb

---
 rtl/serial_capture_arb.sv | 144 ++++++++++++++
 tb/tb_serial_capture_arb.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_capture_arb.sv
// ---------------------------------------------------------------------------
// serial_capture_arb
//
// Two requesters compete for one serial capture channel. A round-robin
// arbiter grants one of them, which then shifts a WIDTH-bit frame in
// LSB-first on its i_a line. The completed frame is presented on o_a with
// o_valid until the consumer takes it with i_ready. If the granted
// requester withdraws its request mid-frame, the capture is abandoned and
// o_abort pulses for one cycle.
//
// Ports
//   i_clk    : sole clock, rising edge
//   i_rst    : asynchronous active-high reset
//   i_req    : [1:0] capture request per requester
//   i_a      : [1:0] serial data bit per requester
//   i_ready  : consumer accepts o_a when o_valid & i_ready
//   o_gnt    : [1:0] one-hot grant, nonzero only while capturing
//   o_a      : [WIDTH-1:0] last completed frame
//   o_src    : requester index that produced o_a
//   o_valid  : o_a holds a completed, unconsumed frame
//   o_abort  : one-cycle pulse when a capture is abandoned
// ---------------------------------------------------------------------------
module serial_capture_arb #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [1:0]       i_req,
    input  logic [1:0]       i_a,
    input  logic             i_ready,
    output logic [1:0]       o_gnt,
    output logic [WIDTH-1:0] o_a,
    output logic             o_src,
    output logic             o_valid,
    output logic             o_abort
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] shadow_r;
    logic             gidx_r;
    logic             ptr_r;

    logic             sel_s;
    logic [WIDTH-1:0] shadow_next_s;

    // Turn a requester index into its one-hot grant pattern.
    function automatic logic [1:0] onehot_grant(input logic idx);
        onehot_grant = idx ? 2'b10 : 2'b01;
    endfunction

    // Arbiter: a lone requester wins outright; a tie is broken by the pointer.
    always_comb begin
        case (i_req)
            2'b01:   sel_s = 1'b0;
            2'b10:   sel_s = 1'b1;
            default: sel_s = ptr_r;
        endcase
    end

    // Shadow word with the granted requester's current bit merged in at cnt.
    always_comb begin
        shadow_next_s        = shadow_r;
        shadow_next_s[cnt_r] = i_a[gidx_r];
    end

    // Capture FSM with registered grant, frame and status outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            shadow_r <= '0;
            gidx_r   <= 1'b0;
            ptr_r    <= 1'b0;
            o_gnt    <= 2'b00;
            o_a      <= '0;
            o_src    <= 1'b0;
            o_valid  <= 1'b0;
            o_abort  <= 1'b0;
        end else begin
            o_abort <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (i_req != 2'b00) begin
                        state_r  <= CAPTURE;
                        gidx_r   <= sel_s;
                        ptr_r    <= ~sel_s;
                        o_gnt    <= onehot_grant(sel_s);
                        cnt_r    <= '0;
                        shadow_r <= '0;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                CAPTURE: begin
                    // Withdrawal wins over sampling, even on the last bit.
                    if (!i_req[gidx_r]) begin
                        state_r  <= IDLE;
                        o_gnt    <= 2'b00;
                        o_abort  <= 1'b1;
                        cnt_r    <= '0;
                        shadow_r <= '0;
                    end else if (cnt_r == LAST_BIT) begin
                        state_r  <= HOLD;
                        o_gnt    <= 2'b00;
                        o_a      <= shadow_next_s;
                        o_src    <= gidx_r;
                        o_valid  <= 1'b1;
                        cnt_r    <= '0;
                        shadow_r <= '0;
                    end else begin
                        shadow_r <= shadow_next_s;
                        cnt_r    <= cnt_r + CW'(1);
                    end
                end
                HOLD: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    o_gnt    <= 2'b00;
                    o_valid  <= 1'b0;
                    cnt_r    <= '0;
                    shadow_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_capture_arb.sv
// ---------------------------------------------------------------------------
// tb_serial_capture_arb
//
// Self-checking bench for serial_capture_arb (WIDTH = 8). A transaction-level
// model tracks which requester owns the channel, how many bits of its frame
// have arrived and the frame value built arithmetically; every cycle the DUT
// outputs are compared against it. Directed scenarios pin known literal
// results, then a long randomized run exercises arbitration, aborts and
// back-pressure.
// ---------------------------------------------------------------------------
module tb_serial_capture_arb;

    localparam int W = 8;

    logic         i_clk;
    logic         i_rst;
    logic [1:0]   i_req;
    logic [1:0]   i_a;
    logic         i_ready;
    logic [1:0]   o_gnt;
    logic [W-1:0] o_a;
    logic         o_src;
    logic         o_valid;
    logic         o_abort;

    serial_capture_arb #(.WIDTH(W)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_req   (i_req),
        .i_a     (i_a),
        .i_ready (i_ready),
        .o_gnt   (o_gnt),
        .o_a     (o_a),
        .o_src   (o_src),
        .o_valid (o_valid),
        .o_abort (o_abort)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: owner of the channel, bits received, frame so far.
    int           m_phase;   // 0 = free, 1 = receiving a frame, 2 = frame waiting
    int           m_g;
    int           m_ptr;
    int           m_k;
    logic [W-1:0] m_word;
    logic [1:0]   m_gnt;
    logic [W-1:0] m_a;
    logic         m_src;
    logic         m_valid;
    logic         m_abort;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_phase = 0; m_g = 0; m_ptr = 0; m_k = 0; m_word = '0;
        m_gnt = 2'b00; m_a = '0; m_src = 1'b0; m_valid = 1'b0; m_abort = 1'b0;
    endtask

    task automatic model_step(input logic [1:0] req, input logic [1:0] a, input logic ready);
        m_abort = 1'b0;
        if (m_phase == 0) begin
            if (req != 2'b00) begin
                if (req == 2'b11) m_g = m_ptr;
                else              m_g = (req == 2'b10) ? 1 : 0;
                m_ptr   = 1 - m_g;
                m_gnt   = (m_g == 1) ? 2'b10 : 2'b01;
                m_phase = 1;
                m_k     = 0;
                m_word  = '0;
            end
        end else if (m_phase == 1) begin
            if (req[m_g] == 1'b0) begin
                m_phase = 0;
                m_gnt   = 2'b00;
                m_abort = 1'b1;
            end else begin
                m_word = m_word + (W'(a[m_g]) << m_k);
                m_k++;
                if (m_k == W) begin
                    m_a     = m_word;
                    m_src   = (m_g == 1);
                    m_valid = 1'b1;
                    m_gnt   = 2'b00;
                    m_phase = 2;
                end
            end
        end else begin
            if (ready) begin
                m_valid = 1'b0;
                m_phase = 0;
            end
        end
    endtask

    task automatic compare();
        check("gnt",   32'(o_gnt),   32'(m_gnt));
        check("a",     32'(o_a),     32'(m_a));
        check("src",   32'(o_src),   32'(m_src));
        check("valid", 32'(o_valid), 32'(m_valid));
        check("abort", 32'(o_abort), 32'(m_abort));
    endtask

    // One clock: drive inputs, advance the model, then check after the edge.
    task automatic cycle(input logic [1:0] req, input logic [1:0] a, input logic ready);
        i_req   = req;
        i_a     = a;
        i_ready = ready;
        model_step(req, a, ready);
        @(posedge i_clk);
        @(negedge i_clk);
        compare();
    endtask

    function automatic logic [1:0] rnd2();
        return 2'($urandom);
    endfunction

    initial begin
        logic [W-1:0] bits;
        logic [1:0]   rreq;
        logic         rbit;

        i_rst = 1'b1; i_req = 2'b00; i_a = 2'b00; i_ready = 1'b0;
        model_reset();
        @(negedge i_clk);
        @(negedge i_clk);
        compare();
        i_rst = 1'b0;

        // Both requesting, consumer always ready: grants alternate 0,1,0.
        cycle(2'b11, rnd2(), 1'b1);
        check("rr_first_gnt", 32'(o_gnt), 32'h1);
        for (int f = 0; f < 3; f++) begin
            for (int b = 0; b < W; b++) cycle(2'b11, rnd2(), 1'b1);
            check("rr_src",   32'(o_src),   32'(f % 2));
            check("rr_valid", 32'(o_valid), 32'h1);
            cycle(2'b11, rnd2(), 1'b1);
            if (f < 2) begin
                cycle(2'b11, rnd2(), 1'b1);
                check("rr_next_gnt", 32'(o_gnt), (f % 2 == 0) ? 32'h2 : 32'h1);
            end
        end

        // Requester 0 alone sends 1,0,1,1,0,0,1,0 LSB first -> 8'h4D.
        bits = 8'h4D;
        cycle(2'b01, 2'b00, 1'b0);
        check("frame_gnt", 32'(o_gnt), 32'h1);
        for (int b = 0; b < W; b++) begin
            rbit = 1'($urandom);
            cycle(2'b01, {rbit, bits[b]}, 1'b0);
        end
        check("frame_a",     32'(o_a),     32'h4D);
        check("frame_src",   32'(o_src),   32'h0);
        check("frame_valid", 32'(o_valid), 32'h1);

        // Back-pressure: frame held stable, no grant while waiting.
        for (int i = 0; i < 5; i++) begin
            cycle(2'b11, rnd2(), 1'b0);
            check("hold_a",     32'(o_a),     32'h4D);
            check("hold_valid", 32'(o_valid), 32'h1);
            check("hold_gnt",   32'(o_gnt),   32'h0);
        end
        cycle(2'b11, rnd2(), 1'b1);
        check("consume_valid", 32'(o_valid), 32'h0);
        check("consume_gnt",   32'(o_gnt),   32'h0);

        // Requester 1 is next in turn; it withdraws after three bits.
        cycle(2'b11, rnd2(), 1'b0);
        check("abort_pre_gnt", 32'(o_gnt), 32'h2);
        for (int b = 0; b < 3; b++) cycle(2'b10, rnd2(), 1'b0);
        cycle(2'b01, rnd2(), 1'b0);
        check("abort_pulse", 32'(o_abort), 32'h1);
        check("abort_gnt",   32'(o_gnt),   32'h0);
        check("abort_a",     32'(o_a),     32'h4D);
        check("abort_valid", 32'(o_valid), 32'h0);
        cycle(2'b00, rnd2(), 1'b0);
        check("abort_once",  32'(o_abort), 32'h0);

        // Randomized traffic: requests toggle occasionally, random back-pressure.
        rreq = 2'b00;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 11) == 0) rreq[0] = ~rreq[0];
            if ($urandom_range(0, 11) == 0) rreq[1] = ~rreq[1];
            cycle(rreq, rnd2(), 1'($urandom_range(0, 2) == 0));
        end

        // Asynchronous reset in the middle of a capture.
        cycle(2'b00, 2'b00, 1'b1);
        cycle(2'b00, 2'b00, 1'b1);
        cycle(2'b00, 2'b00, 1'b1);
        cycle(2'b11, rnd2(), 1'b1);
        for (int b = 0; b < 3; b++) cycle(2'b11, rnd2(), 1'b1);
        #2 i_rst = 1'b1;
        #1;
        check("arst_gnt",   32'(o_gnt),   32'h0);
        check("arst_a",     32'(o_a),     32'h0);
        check("arst_src",   32'(o_src),   32'h0);
        check("arst_valid", 32'(o_valid), 32'h0);
        check("arst_abort", 32'(o_abort), 32'h0);
        model_reset();
        @(posedge i_clk);
        @(negedge i_clk);
        compare();
        i_rst = 1'b0;
        cycle(2'b11, rnd2(), 1'b1);
        check("arst_first_gnt", 32'(o_gnt), 32'h1);
        for (int b = 0; b < W + 1; b++) cycle(2'b11, rnd2(), 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
